// File: rtl/remote_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : remote_arbiter
// Purpose  : Arbitrates N core remote ports onto shared global memory and the
//            device bus (round-robin or TDM). Returns tagged read data.
// Revision : 1.0
// ============================================================================
module remote_arbiter #(
    parameter int NUM_CORES       = 8,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int DEV_ADDR_WIDTH  = 10,
    parameter int GMEM_ADDR_WIDTH = 12,
    parameter int ARB_MODE        = 0,
    localparam int ID_WIDTH       = $clog2(NUM_CORES)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_CORES-1:0]            core_req,
    input  logic [NUM_CORES-1:0]            core_wren,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] core_write_val,
    output logic [NUM_CORES-1:0]            core_grant,
    output logic [NUM_CORES-1:0]            core_read_valid,
    output logic [DATA_WIDTH-1:0]           core_read_val,
    output logic [GMEM_ADDR_WIDTH-1:0]      gmem_addr,
    output logic                            gmem_we,
    output logic [DATA_WIDTH-1:0]           gmem_data,
    input  logic [DATA_WIDTH-1:0]           gmem_q,
    output logic [ID_WIDTH-1:0]             device_core_id,
    output logic                            device_write_en,
    output logic                            device_read_en,
    output logic [DEV_ADDR_WIDTH-1:0]       device_addr,
    output logic [DATA_WIDTH-1:0]           device_data_out,
    input  logic [DATA_WIDTH-1:0]           device_data_in
);

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   rr_next;
    logic                  resp_valid;
    logic [ID_WIDTH-1:0]   resp_id;
    logic                  resp_is_dev;

    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_wren;
    logic                  dev_sel;
    logic                  read_fire;

    // Modular add that wraps at NUM_CORES, which need not be a power of two.
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input int unsigned         off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NUM_CORES)) begin
            sum = sum - 32'(NUM_CORES);
        end
        return sum[ID_WIDTH-1:0];
    endfunction

    generate
        if (ARB_MODE == 1) begin : g_tdm
            always_comb begin
                grant_found = core_req[rr_ptr];
                grant_id    = rr_ptr;
                rr_next     = wrap_add(rr_ptr, 1);
            end
        end else begin : g_rr
            logic [ID_WIDTH-1:0] scan_id;
            // Scan from the farthest offset down so the nearest requester wins.
            always_comb begin
                grant_found = 1'b0;
                grant_id    = rr_ptr;
                scan_id     = '0;
                for (int k = NUM_CORES - 1; k >= 0; k--) begin
                    scan_id = wrap_add(rr_ptr, 32'(k));
                    if (core_req[scan_id]) begin
                        grant_found = 1'b1;
                        grant_id    = scan_id;
                    end
                end
                rr_next = grant_found ? wrap_add(grant_id, 1) : rr_ptr;
            end
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_CORES; i++) begin : g_grant
            assign core_grant[i] = grant_found && (grant_id == ID_WIDTH'(i));
        end
    endgenerate

    assign sel_id    = grant_found ? grant_id : rr_ptr;
    assign sel_addr  = core_addr[sel_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data  = core_write_val[sel_id*DATA_WIDTH +: DATA_WIDTH];
    assign sel_wren  = core_wren[sel_id];
    assign dev_sel   = grant_found && (&sel_addr[ADDR_WIDTH-1:DEV_ADDR_WIDTH]);
    assign read_fire = grant_found && !sel_wren;

    assign gmem_addr       = sel_addr[GMEM_ADDR_WIDTH-1:0];
    assign gmem_data       = sel_data;
    assign gmem_we         = grant_found && sel_wren && !dev_sel;
    assign device_write_en = grant_found && sel_wren && dev_sel;
    assign device_read_en  = grant_found && !sel_wren && dev_sel;
    assign device_addr     = sel_addr[DEV_ADDR_WIDTH-1:0];
    assign device_data_out = sel_data;
    assign device_core_id  = grant_found ? grant_id : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_is_dev <= 1'b0;
        end else begin
            rr_ptr     <= rr_next;
            resp_valid <= read_fire;
            if (read_fire) begin
                resp_id     <= grant_id;
                resp_is_dev <= dev_sel;
            end
        end
    end

    // Both read sources have one cycle of latency, so the response lines up here.
    assign core_read_valid = resp_valid ? ({{(NUM_CORES-1){1'b0}}, 1'b1} << resp_id) : '0;
    assign core_read_val   = resp_is_dev ? device_data_in : gmem_q;

endmodule
`default_nettype wire

// File: tb/tb_remote_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_remote_arbiter
// Purpose  : Directed vector bench for remote_arbiter (RR, TDM and 5-core).
// Revision : 1.0
// ============================================================================
module tb_remote_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic reset_n_b;
    int   tests = 0;
    int   fails = 0;

    // Instance A: 8 cores, round-robin
    logic [7:0]   a_req, a_wren;
    logic [127:0] a_addr, a_wdata;
    logic [15:0]  a_gmem_q, a_dev_in;
    logic [7:0]   a_grant, a_rv;
    logic [15:0]  a_rval, a_gdata, a_dout;
    logic [11:0]  a_gaddr;
    logic         a_gwe, a_dwe, a_dre;
    logic [2:0]   a_dcid;
    logic [9:0]   a_daddr;

    remote_arbiter #(.NUM_CORES(8), .ARB_MODE(0)) u_a (
        .clk(clk), .reset_n(reset_n),
        .core_req(a_req), .core_wren(a_wren), .core_addr(a_addr), .core_write_val(a_wdata),
        .core_grant(a_grant), .core_read_valid(a_rv), .core_read_val(a_rval),
        .gmem_addr(a_gaddr), .gmem_we(a_gwe), .gmem_data(a_gdata), .gmem_q(a_gmem_q),
        .device_core_id(a_dcid), .device_write_en(a_dwe), .device_read_en(a_dre),
        .device_addr(a_daddr), .device_data_out(a_dout), .device_data_in(a_dev_in)
    );

    // Instance B: 8 cores, TDM
    logic [7:0]   b_req, b_wren, b_grant, b_rv;
    logic [127:0] b_addr, b_wdata;
    logic [15:0]  b_rval, b_gdata, b_dout, b_gmem_q, b_dev_in;
    logic [11:0]  b_gaddr;
    logic         b_gwe, b_dwe, b_dre;
    logic [2:0]   b_dcid;
    logic [9:0]   b_daddr;

    remote_arbiter #(.NUM_CORES(8), .ARB_MODE(1)) u_b (
        .clk(clk), .reset_n(reset_n_b),
        .core_req(b_req), .core_wren(b_wren), .core_addr(b_addr), .core_write_val(b_wdata),
        .core_grant(b_grant), .core_read_valid(b_rv), .core_read_val(b_rval),
        .gmem_addr(b_gaddr), .gmem_we(b_gwe), .gmem_data(b_gdata), .gmem_q(b_gmem_q),
        .device_core_id(b_dcid), .device_write_en(b_dwe), .device_read_en(b_dre),
        .device_addr(b_daddr), .device_data_out(b_dout), .device_data_in(b_dev_in)
    );

    // Instance C: 5 cores, round-robin
    logic [4:0]   c_req, c_wren, c_grant, c_rv;
    logic [79:0]  c_addr, c_wdata;
    logic [15:0]  c_rval, c_gdata, c_dout, c_gmem_q, c_dev_in;
    logic [11:0]  c_gaddr;
    logic         c_gwe, c_dwe, c_dre;
    logic [2:0]   c_dcid;
    logic [9:0]   c_daddr;

    remote_arbiter #(.NUM_CORES(5), .ARB_MODE(0)) u_c (
        .clk(clk), .reset_n(reset_n_b),
        .core_req(c_req), .core_wren(c_wren), .core_addr(c_addr), .core_write_val(c_wdata),
        .core_grant(c_grant), .core_read_valid(c_rv), .core_read_val(c_rval),
        .gmem_addr(c_gaddr), .gmem_we(c_gwe), .gmem_data(c_gdata), .gmem_q(c_gmem_q),
        .device_core_id(c_dcid), .device_write_en(c_dwe), .device_read_en(c_dre),
        .device_addr(c_daddr), .device_data_out(c_dout), .device_data_in(c_dev_in)
    );

    // Global memory model for A: unwritten words return a fixed address-derived pattern.
    logic [15:0] mem     [4096];
    logic        written [4096];

    function automatic logic [15:0] dflt(input logic [11:0] a);
        return (a == 12'h123) ? 16'hBEEF : (16'h1000 + {8'h00, a[7:0]});
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4096; i++) written[i] <= 1'b0;
        end else if (a_gwe) begin
            mem[a_gaddr]     <= a_gdata;
            written[a_gaddr] <= 1'b1;
        end
        a_gmem_q <= written[a_gaddr] ? mem[a_gaddr] : dflt(a_gaddr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  req;
        logic [7:0]  grant;
        logic [7:0]  rv;
        logic [15:0] val;
        logic        dre;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] v,
                                input logic [15:0] d, input logic dr);
        vec_t t;
        t.req = r; t.grant = g; t.rv = v; t.val = d; t.dre = dr;
        return t;
    endfunction

    initial begin
        // All-core reads: back-to-back responses, then cores 2/5 only, then core 3 alone.
        vecs[0]  = mk(8'hFF, 8'h01, 8'h00, 16'h0000, 1'b0);
        vecs[1]  = mk(8'hFF, 8'h02, 8'h01, 16'h1000, 1'b0);
        vecs[2]  = mk(8'hFF, 8'h04, 8'h02, 16'h1001, 1'b0);
        vecs[3]  = mk(8'hFF, 8'h08, 8'h04, 16'h1002, 1'b0);
        vecs[4]  = mk(8'hFF, 8'h10, 8'h08, 16'hBEEF, 1'b0);
        vecs[5]  = mk(8'hFF, 8'h20, 8'h10, 16'h1004, 1'b0);
        vecs[6]  = mk(8'hFF, 8'h40, 8'h20, 16'h1005, 1'b1);
        vecs[7]  = mk(8'hFF, 8'h80, 8'h40, 16'hA5A5, 1'b0);
        vecs[8]  = mk(8'hFF, 8'h01, 8'h80, 16'h1007, 1'b0);
        vecs[9]  = mk(8'h24, 8'h04, 8'h01, 16'h1000, 1'b0);
        vecs[10] = mk(8'h24, 8'h20, 8'h04, 16'h1002, 1'b0);
        vecs[11] = mk(8'h24, 8'h04, 8'h20, 16'h1005, 1'b0);
        vecs[12] = mk(8'h24, 8'h20, 8'h04, 16'h1002, 1'b0);
        vecs[13] = mk(8'h08, 8'h08, 8'h20, 16'h1005, 1'b0);
        vecs[14] = mk(8'h00, 8'h00, 8'h08, 16'hBEEF, 1'b0);
        vecs[15] = mk(8'h00, 8'h00, 8'h00, 16'h0000, 1'b0);

        reset_n = 1'b0; reset_n_b = 1'b0;
        a_req = '0; a_wren = '0; a_dev_in = 16'hA5A5;
        for (int i = 0; i < 8; i++) begin
            a_addr[i*16 +: 16]  = 16'h0200 + 16'(i);
            a_wdata[i*16 +: 16] = 16'h1230 + 16'(i);
        end
        a_addr[3*16 +: 16]  = 16'h0123;
        a_addr[6*16 +: 16]  = 16'hFC05;
        a_wdata[6*16 +: 16] = 16'h1234;

        b_req = 8'h20; b_wren = '0; b_addr = '0; b_wdata = '0; b_gmem_q = '0; b_dev_in = '0;
        c_req = 5'h1F; c_wren = 5'h1F; c_wdata = '0; c_gmem_q = '0; c_dev_in = '0;
        for (int i = 0; i < 5; i++) c_addr[i*16 +: 16] = 16'(i);
        c_addr[15:0] = 16'h1FFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset grant",   32'(a_grant), 32'h0);
        check("reset rvalid",  32'(a_rv),    32'h0);
        check("reset gmem_we", 32'(a_gwe),   32'h0);
        check("reset dev_we",  32'(a_dwe),   32'h0);
        check("reset dev_re",  32'(a_dre),   32'h0);
        check("reset core_id", 32'(a_dcid),  32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            a_req = vecs[i].req;
            @(negedge clk);
            check($sformatf("row%0d grant", i),  32'(a_grant), 32'(vecs[i].grant));
            check($sformatf("row%0d rvalid", i), 32'(a_rv),    32'(vecs[i].rv));
            check($sformatf("row%0d dev_re", i), 32'(a_dre),   32'(vecs[i].dre));
            if (vecs[i].rv != 8'h00)
                check($sformatf("row%0d rval", i), 32'(a_rval), 32'(vecs[i].val));
            @(posedge clk); #1;
        end

        // Core 6 device write
        a_req = 8'h40; a_wren = 8'h40;
        @(negedge clk);
        check("dw grant",   32'(a_grant), 32'h40);
        check("dw dev_we",  32'(a_dwe),   32'h1);
        check("dw addr",    32'(a_daddr), 32'h005);
        check("dw core_id", 32'(a_dcid),  32'h6);
        check("dw gmem_we", 32'(a_gwe),   32'h0);
        check("dw data",    32'(a_dout),  32'h1234);
        @(posedge clk); #1;

        // Core 1 gmem write, then read it back
        a_req = 8'h02; a_wren = 8'h02;
        @(negedge clk);
        check("gw grant",   32'(a_grant), 32'h02);
        check("gw gmem_we", 32'(a_gwe),   32'h1);
        check("gw addr",    32'(a_gaddr), 32'h201);
        check("gw data",    32'(a_gdata), 32'h1231);
        check("gw dev_we",  32'(a_dwe),   32'h0);
        @(posedge clk); #1;
        a_wren = 8'h00;
        @(negedge clk);
        check("gr grant",  32'(a_grant), 32'h02);
        check("gw no rsp", 32'(a_rv),    32'h0);
        @(posedge clk); #1;
        a_req = 8'h00;
        @(negedge clk);
        check("gr rvalid", 32'(a_rv),   32'h02);
        check("gr rval",   32'(a_rval), 32'h1231);
        @(posedge clk); #1;

        // Reset asserted the cycle after a read grant
        a_req = 8'h08;
        @(negedge clk);
        check("rst read grant", 32'(a_grant), 32'h08);
        @(posedge clk); #1;
        reset_n = 1'b0; a_req = 8'h00;
        #1;
        check("rst async rvalid", 32'(a_rv), 32'h0);
        @(negedge clk);
        check("rst hold rvalid", 32'(a_rv), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst post rvalid", 32'(a_rv), 32'h0);
        @(posedge clk); #1;
        a_req = 8'hFF;
        @(negedge clk);
        check("rst rr_ptr", 32'(a_grant), 32'h01);
        @(posedge clk); #1;
        a_req = 8'h00;

        // TDM core 5 alone, and the 5-core wrap, from a common reset release
        reset_n_b = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            check($sformatf("tdm k%0d", k), 32'(b_grant), (k % 8 == 5) ? 32'h20 : 32'h0);
            if (k < 6)
                check($sformatf("n5 k%0d", k), 32'(c_grant), 32'h1 << (k % 5));
            if (k == 0)
                check("n5 alias", 32'(c_gaddr), 32'hFFF);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
